// File: rtl/dbg_mem_arbiter.sv
// dbg_mem_arbiter
//   Shares port 2 of InstRAM and DataRAM between two host-side requesters
//   (m0 = program loader, m1 = debug monitor). One access at a time,
//   round-robin between requesters, fixed-latency req/ack handshake.
//
// Ports
//   clk, rst              core clock, asynchronous active-low reset
//   mX_req/sel/we/addr/wdata  request from requester X (sel: 0 = DataRAM, 1 = InstRAM;
//                             we = 0 means read)
//   mX_ack, mX_rdata      one-cycle completion pulse and read data for requester X
//   inst_a2/wd2/we2/rd2   InstRAM port 2
//   data_a2/wd2/we2/rd2   DataRAM port 2
//   busy                  high whenever an access is in progress
//   gnt_id                index of the current or most recent grant
//
// State table
//   state | meaning
//   IDLE  | no access in progress, arbitrating incoming requests
//   ISSUE | drive address/write data/byte enables to the selected RAM
//   WAIT  | wait RD_LAT cycles for the RAM read data, address held
//   RESP  | pulse ack with the captured read data
module dbg_mem_arbiter #(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_sel,
  input  logic [3:0]        m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_ack,
  output logic [31:0]       m0_rdata,
  input  logic              m1_req,
  input  logic              m1_sel,
  input  logic [3:0]        m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_ack,
  output logic [31:0]       m1_rdata,
  output logic [ADDR_W-1:0] inst_a2,
  output logic [31:0]       inst_wd2,
  output logic [3:0]        inst_we2,
  input  logic [31:0]       inst_rd2,
  output logic [ADDR_W-1:0] data_a2,
  output logic [31:0]       data_wd2,
  output logic [3:0]        data_we2,
  input  logic [31:0]       data_rd2,
  output logic              busy,
  output logic              gnt_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } stateT;

  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT);

  stateT             curState;
  stateT             nxtState;
  logic              anyReq;
  logic              grantWin;
  logic              lastGrant;
  logic              gntReg;
  logic              selReg;
  logic [3:0]        weReg;
  logic [ADDR_W-1:0] addrReg;
  logic [31:0]       wdataReg;
  logic [31:0]       rdataReg;
  logic [2:0]        waitCnt;

  // Round-robin: on a tie the requester that did not win last time gets it.
  assign anyReq   = m0_req | m1_req;
  assign grantWin = (m0_req & m1_req) ? ~lastGrant : m1_req;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      curState <= IDLE;
    end else begin
      curState <= nxtState;
    end
  end

  // Next-state logic
  always_comb begin
    nxtState = curState;
    unique case (curState)
      IDLE:    if (anyReq) nxtState = ISSUE;
      ISSUE:   nxtState = WAIT;
      WAIT:    if (waitCnt == 3'd1) nxtState = RESP;
      RESP:    nxtState = IDLE;
      default: nxtState = IDLE;
    endcase
  end

  // Request latch, wait counter, read-data capture and grant bookkeeping.
  // lastGrant resets to 1 so m0 wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lastGrant <= 1'b1;
      gntReg    <= 1'b0;
      selReg    <= 1'b0;
      weReg     <= '0;
      addrReg   <= '0;
      wdataReg  <= '0;
      rdataReg  <= '0;
      waitCnt   <= '0;
    end else begin
      unique case (curState)
        IDLE: begin
          if (anyReq) begin
            selReg    <= grantWin ? m1_sel   : m0_sel;
            weReg     <= grantWin ? m1_we    : m0_we;
            addrReg   <= grantWin ? m1_addr  : m0_addr;
            wdataReg  <= grantWin ? m1_wdata : m0_wdata;
            gntReg    <= grantWin;
            lastGrant <= grantWin;
          end
        end
        ISSUE: waitCnt <= LAT_LOAD;
        WAIT: begin
          waitCnt <= waitCnt - 3'd1;
          if (waitCnt == 3'd1) begin
            rdataReg <= selReg ? inst_rd2 : data_rd2;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from state only, so reset clears them (including an
  // in-flight write enable) without waiting for a clock.
  always_comb begin
    inst_a2  = '0;
    inst_wd2 = '0;
    inst_we2 = '0;
    data_a2  = '0;
    data_wd2 = '0;
    data_we2 = '0;
    m0_ack   = 1'b0;
    m0_rdata = '0;
    m1_ack   = 1'b0;
    m1_rdata = '0;
    unique case (curState)
      ISSUE: begin
        if (selReg) begin
          inst_a2  = addrReg;
          inst_wd2 = wdataReg;
          inst_we2 = weReg;
        end else begin
          data_a2  = addrReg;
          data_wd2 = wdataReg;
          data_we2 = weReg;
        end
      end
      WAIT: begin
        if (selReg) inst_a2 = addrReg;
        else        data_a2 = addrReg;
      end
      RESP: begin
        if (gntReg) begin
          m1_ack   = 1'b1;
          m1_rdata = rdataReg;
        end else begin
          m0_ack   = 1'b1;
          m0_rdata = rdataReg;
        end
      end
      default: ;
    endcase
  end

  assign busy   = (curState != IDLE);
  assign gnt_id = gntReg;

endmodule

// File: tb/tb_dbg_mem_arbiter.sv
// Bench for dbg_mem_arbiter: two instances (RD_LAT = 1 and RD_LAT = 3) share
// the same stimulus. A transaction-timeline model predicts every output on
// every cycle; directed checks pin ack timing, grant order and read data.
module tb_dbg_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        m0Req, m1Req, m0Sel, m1Sel;
  logic [3:0]  m0We, m1We;
  logic [31:0] m0Addr, m1Addr, m0Wdata, m1Wdata;
  logic [31:0] instRd, dataRd;
  logic [31:0] instConst, dataConst, patRd;
  logic        rdMode;
  logic        checkEn;

  logic        m0Ack[2], m1Ack[2], busyO[2], gntO[2];
  logic [31:0] m0Rdata[2], m1Rdata[2];
  logic [31:0] instA2[2], instWd2[2], dataA2[2], dataWd2[2];
  logic [3:0]  instWe2[2], dataWe2[2];

  int nTests = 0;
  int nFail  = 0;
  int edgeCnt = 0;

  assign instRd = rdMode ? patRd : instConst;
  assign dataRd = rdMode ? patRd : dataConst;

  dbg_mem_arbiter #(.RD_LAT(1), .ADDR_W(32)) u1 (
    .clk(clk), .rst(rst),
    .m0_req(m0Req), .m0_sel(m0Sel), .m0_we(m0We), .m0_addr(m0Addr), .m0_wdata(m0Wdata),
    .m0_ack(m0Ack[0]), .m0_rdata(m0Rdata[0]),
    .m1_req(m1Req), .m1_sel(m1Sel), .m1_we(m1We), .m1_addr(m1Addr), .m1_wdata(m1Wdata),
    .m1_ack(m1Ack[0]), .m1_rdata(m1Rdata[0]),
    .inst_a2(instA2[0]), .inst_wd2(instWd2[0]), .inst_we2(instWe2[0]), .inst_rd2(instRd),
    .data_a2(dataA2[0]), .data_wd2(dataWd2[0]), .data_we2(dataWe2[0]), .data_rd2(dataRd),
    .busy(busyO[0]), .gnt_id(gntO[0])
  );

  dbg_mem_arbiter #(.RD_LAT(3), .ADDR_W(32)) u3 (
    .clk(clk), .rst(rst),
    .m0_req(m0Req), .m0_sel(m0Sel), .m0_we(m0We), .m0_addr(m0Addr), .m0_wdata(m0Wdata),
    .m0_ack(m0Ack[1]), .m0_rdata(m0Rdata[1]),
    .m1_req(m1Req), .m1_sel(m1Sel), .m1_we(m1We), .m1_addr(m1Addr), .m1_wdata(m1Wdata),
    .m1_ack(m1Ack[1]), .m1_rdata(m1Rdata[1]),
    .inst_a2(instA2[1]), .inst_wd2(instWd2[1]), .inst_we2(instWe2[1]), .inst_rd2(instRd),
    .data_a2(dataA2[1]), .data_wd2(dataWd2[1]), .data_we2(dataWe2[1]), .data_rd2(dataRd),
    .busy(busyO[1]), .gnt_id(gntO[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- model: one transaction record per instance ----------------
  int          L[2] = '{1, 3};
  bit          mActive[2], mLast[2], mGnt[2], mId[2], mSel[2];
  int          mG[2];
  logic [3:0]  mWe[2];
  logic [31:0] mAddr[2], mWdata[2], mCap[2];

  // A grant at edge g gives: ISSUE after g, WAIT for L cycles, RESP after
  // g+L+1, IDLE after g+L+2; the next grant can happen at edge g+L+3.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        mActive[i] = 1'b0;
        mLast[i]   = 1'b1;
        mGnt[i]    = 1'b0;
        mCap[i]    = '0;
        mG[i]      = -100;
      end
    end else begin
      edgeCnt++;
      for (int i = 0; i < 2; i++) begin
        int offPrev;
        bit w;
        offPrev = edgeCnt - 1 - mG[i];
        if (mActive[i] && offPrev == L[i]) mCap[i] = mSel[i] ? instRd : dataRd;
        if ((!mActive[i] || offPrev >= L[i] + 2) && (m0Req || m1Req)) begin
          w = (m0Req && m1Req) ? !mLast[i] : m1Req;
          mId[i]     = w;
          mSel[i]    = w ? m1Sel : m0Sel;
          mWe[i]     = w ? m1We : m0We;
          mAddr[i]   = w ? m1Addr : m0Addr;
          mWdata[i]  = w ? m1Wdata : m0Wdata;
          mG[i]      = edgeCnt;
          mActive[i] = 1'b1;
          mLast[i]   = w;
          mGnt[i]    = w;
        end
      end
    end
  end

  // Read-data pattern that changes every cycle, used to see which cycle was captured.
  always @(posedge clk) begin
    #1 patRd = 32'hA5000000 | (32'(edgeCnt) & 32'h0000FFFF);
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst && checkEn) begin
      for (int i = 0; i < 2; i++) begin
        int off;
        bit inIss, inWait, inResp;
        logic [31:0] eA, eWd;
        logic [3:0]  eWe;
        off    = edgeCnt - mG[i];
        inIss  = mActive[i] && off == 0;
        inWait = mActive[i] && off >= 1 && off <= L[i];
        inResp = mActive[i] && off == L[i] + 1;
        eA  = (inIss || inWait) ? mAddr[i] : 32'h0;
        eWd = inIss ? mWdata[i] : 32'h0;
        eWe = inIss ? mWe[i] : 4'h0;
        chk($sformatf("u%0d.inst_port", L[i]), {instA2[i], instWd2[i], instWe2[i]},
            mSel[i] ? {eA, eWd, eWe} : 68'h0);
        chk($sformatf("u%0d.data_port", L[i]), {dataA2[i], dataWd2[i], dataWe2[i]},
            !mSel[i] ? {eA, eWd, eWe} : 68'h0);
        chk($sformatf("u%0d.ack_rdata", L[i]), {m0Ack[i], m1Ack[i], m0Rdata[i], m1Rdata[i]},
            {inResp && !mId[i], inResp && mId[i],
             (inResp && !mId[i]) ? mCap[i] : 32'h0,
             (inResp && mId[i]) ? mCap[i] : 32'h0});
        chk($sformatf("u%0d.busy_gnt", L[i]), {busyO[i], gntO[i]},
            {inIss || inWait || inResp, mGnt[i]});
      end
    end
  end

  // ---------------- ack recorder for directed checks ----------------
  typedef struct {
    int          e;
    bit          id;
    logic [31:0] d;
  } ackRecT;
  ackRecT q1[$];
  ackRecT q3[$];

  always @(negedge clk) begin
    if (rst) begin
      if (m0Ack[0]) q1.push_back('{edgeCnt, 1'b0, m0Rdata[0]});
      if (m1Ack[0]) q1.push_back('{edgeCnt, 1'b1, m1Rdata[0]});
      if (m0Ack[1]) q3.push_back('{edgeCnt, 1'b0, m0Rdata[1]});
      if (m1Ack[1]) q3.push_back('{edgeCnt, 1'b1, m1Rdata[1]});
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int r;
    rst = 1'b0; checkEn = 1'b0; rdMode = 1'b0;
    m0Req = 0; m1Req = 0; m0Sel = 0; m1Sel = 0; m0We = 0; m1We = 0;
    m0Addr = 0; m1Addr = 0; m0Wdata = 0; m1Wdata = 0;
    instConst = 0; dataConst = 0;

    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst.busy", busyO[i], 1'b0);
      chk("rst.gnt_id", gntO[i], 1'b0);
      chk("rst.acks", {m0Ack[i], m1Ack[i], m0Rdata[i], m1Rdata[i]}, 66'h0);
      chk("rst.ports", {instA2[i], instWe2[i], dataA2[i], dataWe2[i]}, 72'h0);
    end
    @(negedge clk); #2;
    rst = 1'b1; checkEn = 1'b1;

    // Both requesters hold req from reset: grants alternate starting with m0.
    @(posedge clk); #1;
    r = edgeCnt;
    instConst = 32'h11110000; dataConst = 32'h22220000;
    m0Sel = 1; m0We = 0;    m0Addr = 32'h40; m0Wdata = 32'h0;
    m1Sel = 0; m1We = 4'hF; m1Addr = 32'h80; m1Wdata = 32'h000055AA;
    m0Req = 1; m1Req = 1;
    repeat (16) @(posedge clk);
    #1 m0Req = 0; m1Req = 0;
    repeat (8) @(posedge clk);
    #1;
    chk("alt.u1.count", q1.size(), 4);
    for (int k = 0; k < 4 && k < q1.size(); k++) begin
      chk("alt.u1.edge", q1[k].e, r + 3 + 4 * k);
      chk("alt.u1.id", q1[k].id, k % 2);
    end
    chk("alt.u3.count", q3.size(), 3);
    for (int k = 0; k < 3 && k < q3.size(); k++) begin
      chk("alt.u3.edge", q3[k].e, r + 5 + 6 * k);
      chk("alt.u3.id", q3[k].id, k % 2);
    end
    q1.delete(); q3.delete();

    // m0 reads InstRAM 0x10, RAM returns 0xDEADBEEF.
    @(posedge clk); #1;
    r = edgeCnt;
    instConst = 32'hDEADBEEF; dataConst = 32'h0;
    m0Sel = 1; m0We = 0; m0Addr = 32'h10; m0Req = 1;
    @(posedge clk); #1 m0Req = 0;
    @(negedge clk);
    chk("rd.u1.inst_a2", instA2[0], 32'h10);
    chk("rd.u3.inst_a2", instA2[1], 32'h10);
    chk("rd.u1.data_a2", dataA2[0], 32'h0);
    repeat (8) @(posedge clk);
    #1;
    chk("rd.u1.count", q1.size(), 1);
    if (q1.size() > 0) begin
      chk("rd.u1.edge", q1[0].e, r + 3);
      chk("rd.u1.rdata", q1[0].d, 32'hDEADBEEF);
    end
    chk("rd.u3.count", q3.size(), 1);
    if (q3.size() > 0) begin
      chk("rd.u3.edge", q3[0].e, r + 5);
      chk("rd.u3.rdata", q3[0].d, 32'hDEADBEEF);
    end
    q1.delete(); q3.delete();

    // m1 writes DataRAM 0x200, we = 0011.
    @(posedge clk); #1;
    r = edgeCnt;
    dataConst = 32'h0BADF00D;
    m1Sel = 0; m1We = 4'b0011; m1Addr = 32'h200; m1Wdata = 32'h1234ABCD; m1Req = 1;
    @(posedge clk); #1 m1Req = 0;
    @(negedge clk);
    chk("wr.u1.data_we2", dataWe2[0], 4'b0011);
    chk("wr.u1.data_wd2", dataWd2[0], 32'h1234ABCD);
    chk("wr.u1.inst_we2", instWe2[0], 4'h0);
    chk("wr.u3.data_we2", dataWe2[1], 4'b0011);
    @(negedge clk);
    chk("wr.u1.we2_wait", dataWe2[0], 4'h0);
    chk("wr.u1.a2_wait", dataA2[0], 32'h200);
    repeat (8) @(posedge clk);
    #1;
    chk("wr.u1.count", q1.size(), 1);
    if (q1.size() > 0) begin
      chk("wr.u1.edge", q1[0].e, r + 3);
      chk("wr.u1.id", q1[0].id, 1'b1);
      chk("wr.u1.rdata", q1[0].d, 32'h0BADF00D);
    end
    chk("wr.u3.count", q3.size(), 1);
    if (q3.size() > 0) chk("wr.u3.edge", q3[0].e, r + 5);
    q1.delete(); q3.delete();

    // Read data changes every cycle: rdata must be the value on the last WAIT cycle.
    @(posedge clk); #1;
    r = edgeCnt;
    rdMode = 1;
    m0Sel = 0; m0We = 0; m0Addr = 32'h1C; m0Req = 1;
    @(posedge clk); #1 m0Req = 0;
    repeat (8) @(posedge clk);
    #1;
    chk("lat.u1.count", q1.size(), 1);
    if (q1.size() > 0) begin
      chk("lat.u1.edge", q1[0].e, r + 3);
      chk("lat.u1.rdata", q1[0].d, 32'hA5000000 | (32'(r + 2) & 32'hFFFF));
    end
    chk("lat.u3.count", q3.size(), 1);
    if (q3.size() > 0) begin
      chk("lat.u3.edge", q3[0].e, r + 5);
      chk("lat.u3.rdata", q3[0].d, 32'hA5000000 | (32'(r + 4) & 32'hFFFF));
    end
    rdMode = 0;
    q1.delete(); q3.delete();

    // m1 drops req during WAIT: ack still pulses once, nothing else granted.
    @(posedge clk); #1;
    r = edgeCnt;
    instConst = 32'h77778888;
    m1Sel = 1; m1We = 0; m1Addr = 32'h300; m1Req = 1;
    @(posedge clk); #1;
    @(posedge clk); #1 m1Req = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("drop.u1.count", q1.size(), 1);
    if (q1.size() > 0) begin
      chk("drop.u1.edge", q1[0].e, r + 3);
      chk("drop.u1.rdata", q1[0].d, 32'h77778888);
    end
    chk("drop.u3.count", q3.size(), 1);
    if (q3.size() > 0) chk("drop.u3.edge", q3[0].e, r + 5);
    chk("drop.u1.busy", busyO[0], 1'b0);
    chk("drop.u3.busy", busyO[1], 1'b0);
    q1.delete(); q3.delete();

    // Reset during the ISSUE cycle of a write.
    @(posedge clk); #1;
    m0Sel = 0; m0We = 4'hF; m0Addr = 32'h44; m0Wdata = 32'hCAFEF00D; m0Req = 1;
    @(posedge clk); #1 m0Req = 0;
    @(negedge clk);
    chk("rstw.u1.we_pre", dataWe2[0], 4'hF);
    #1 rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rstw.we2", dataWe2[i], 4'h0);
      chk("rstw.busy", busyO[i], 1'b0);
      chk("rstw.acks", {m0Ack[i], m1Ack[i]}, 2'b00);
    end
    @(negedge clk); #2 rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rstw.u1.no_ack", q1.size(), 0);
    chk("rstw.u3.no_ack", q3.size(), 0);
    r = edgeCnt;
    m0Sel = 1; m0We = 0; m0Addr = 32'h8;
    m1Sel = 0; m1We = 0; m1Addr = 32'hC;
    m0Req = 1; m1Req = 1;
    @(posedge clk); #1 m0Req = 0; m1Req = 0;
    @(negedge clk);
    chk("tie.u1.gnt_id", gntO[0], 1'b0);
    chk("tie.u3.gnt_id", gntO[1], 1'b0);
    chk("tie.u1.inst_a2", instA2[0], 32'h8);
    repeat (8) @(posedge clk);
    #1;
    chk("tie.u1.count", q1.size(), 1);
    if (q1.size() > 0) begin
      chk("tie.u1.edge", q1[0].e, r + 3);
      chk("tie.u1.id", q1[0].id, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
